// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared types and constants for the RAM port arbiter.
//   NUM_REQ  number of requesters sharing the RAM (fetch = 0, load/store = 1)
//   state_e  sequencer state: IDLE (accepting) / RESP (holding a response)
//   gid_t    grant id, names one requester
package ram_arb_pkg;

  localparam int NUM_REQ = 2;

  typedef enum logic {
    IDLE,
    RESP
  } state_e;

  typedef logic [0:0] gid_t;

endpackage

// File: rtl/ram_arb_picker.sv
// ram_arb_picker: combinational winner select between the two requesters.
//   Optional macro: RAM_ARB_RR_EN
//     defined   -> round-robin, the preferred port is named by ptr
//     undefined -> fixed priority, port 0 always wins, ptr is ignored
// Ports:
//   req_valid  in   per-requester request valid
//   ptr        in   current priority pointer (preferred port)
//   grant      out  one-hot grant, all zero when nobody requests
//   gid        out  index of the granted port
//   any        out  at least one request is pending
//   ptr_next   out  pointer value to load when the grant is taken
module ram_arb_picker
  import ram_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req_valid,
  input  gid_t               ptr,
  output logic [NUM_REQ-1:0] grant,
  output gid_t               gid,
  output logic               any,
  output gid_t               ptr_next
);

  always_comb begin
    // NOTE: every output gets a value before any branch, so no path through
    // this block can leave a signal unassigned and infer a latch.
    grant    = '0;
    gid      = '0;
    ptr_next = '0;
    any      = |req_valid;
`ifdef RAM_ARB_RR_EN
    // Only a genuine conflict consults the pointer; a lone requester wins.
    if (req_valid == 2'b11) gid = ptr;
    else                    gid = req_valid[0] ? 1'b0 : 1'b1;
    // Prefer the port that just lost (or did not ask) on the next conflict.
    ptr_next = ~gid;
`else
    gid = req_valid[0] ? 1'b0 : 1'b1;
`endif
    if (any) grant[gid] = 1'b1;
  end

`ifndef RAM_ARB_RR_EN
  // Fixed priority never looks at the pointer.
  logic unused_ptr;
  assign unused_ptr = ^ptr;
`endif

endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares one single-port RAM between instruction fetch
// (port 0) and data load/store (port 1). Each grant performs exactly one RAM
// access in the accept cycle, registers the read data (zero for writes) and
// holds it as a response to the granted port until it is taken.
// Accept and response never overlap: at most one access every two cycles.
// Optional macro: RAM_ARB_RR_EN selects round-robin arbitration (see picker).
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   req_valid/ready   per-port request handshake (bit n = port n)
//   req_addr/wdata/wmask/wen  per-port request fields, port n in slice n
//   resp_valid/ready  per-port response handshake
//   resp_rdata        response data, shared, qualified by resp_valid
//   ram_en/addr/wdata/wmask/wen  RAM access, zero outside an accept cycle
//   ram_rdata         RAM read data, combinational from ram_en/ram_addr
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
  input  logic [NUM_REQ*DATA_W/8-1:0] req_wmask,
  input  logic [NUM_REQ-1:0]          req_wen,
  output logic [NUM_REQ-1:0]          resp_valid,
  input  logic [NUM_REQ-1:0]          resp_ready,
  output logic [DATA_W-1:0]           resp_rdata,
  output logic                        ram_en,
  output logic [ADDR_W-1:0]           ram_addr,
  output logic [DATA_W-1:0]           ram_wdata,
  output logic [DATA_W/8-1:0]         ram_wmask,
  output logic                        ram_wen,
  input  logic [DATA_W-1:0]           ram_rdata
);

  localparam int MASK_W = DATA_W / 8;

  state_e               state_q, state_d;
  gid_t                 gid_q;
  gid_t                 ptr_q, ptr_d;
  logic [DATA_W-1:0]    rdata_q;
  logic [NUM_REQ-1:0]   pick_grant;
  gid_t                 pick_gid;
  logic                 pick_any;
  logic                 accept;

  ram_arb_picker u_picker (
    .req_valid (req_valid),
    .ptr       (ptr_q),
    .grant     (pick_grant),
    .gid       (pick_gid),
    .any       (pick_any),
    .ptr_next  (ptr_d)
  );

  always_comb begin
    state_d    = state_q;
    accept     = 1'b0;
    req_ready  = '0;
    resp_valid = '0;
    ram_en     = 1'b0;
    ram_wen    = 1'b0;
    ram_addr   = '0;
    ram_wdata  = '0;
    ram_wmask  = '0;
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          accept    = 1'b1;
          req_ready = pick_grant;
          ram_en    = 1'b1;
          ram_wen   = req_wen[pick_gid];
          ram_addr  = req_addr[int'(pick_gid)*ADDR_W +: ADDR_W];
          ram_wdata = req_wdata[int'(pick_gid)*DATA_W +: DATA_W];
          ram_wmask = req_wmask[int'(pick_gid)*MASK_W +: MASK_W];
          state_d   = RESP;
        end
      end
      RESP: begin
        resp_valid[gid_q] = 1'b1;
        if (resp_ready[gid_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignment so every flop samples
  // pre-edge values; blocking here would let one register see another's update.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      gid_q   <= '0;
      ptr_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        gid_q   <= pick_gid;
        // Constant zero under fixed priority, so the register folds away.
        ptr_q   <= ptr_d;
        rdata_q <= ram_wen ? '0 : ram_rdata;
      end
    end
  end

  // Stays valid after the handshake but is only meaningful under resp_valid.
  assign resp_rdata = rdata_q;

  // Requester protocol: a pending request stays up with frozen fields.
  for (genvar n = 0; n < NUM_REQ; n++) begin : g_proto
    a_hold_valid : assert property (@(posedge clk) disable iff (reset)
      req_valid[n] && !req_ready[n] |=> req_valid[n]);
    a_hold_fields : assert property (@(posedge clk) disable iff (reset)
      req_valid[n] && !req_ready[n] |=>
        $stable(req_addr[n*ADDR_W +: ADDR_W]) &&
        $stable(req_wdata[n*DATA_W +: DATA_W]) &&
        $stable(req_wmask[n*MASK_W +: MASK_W]) &&
        $stable(req_wen[n]));
  end

  a_one_ready : assert property (@(posedge clk) disable iff (reset)
    $onehot0(req_ready));

endmodule
